fractal_sync_arb: RTL
=====================

// Module: fractal_sync_arb
// PURPOSE
//  Per-node request arbiter/controller of the fractal sync tree. Accepts barrier requests
//  from the two children (east/north, west/south), terminates those whose level equals this
//  node's level using a direct-mapped arrival RF, forwards higher-level ones to the parent,
//  and merges local completions with parent responses onto one child-response channel.
// PARAMETERS
//  LVL_WIDTH  4  width of barrier level field
//  ID_WIDTH   2  width of barrier id; arrival RF has 2**ID_WIDTH entries x 2 bits (EN,WS)
//  NODE_LEVEL 1  level terminated at this node (1..2**LVL_WIDTH-1)
// PORTS
//  clk_i            in   1          clock
//  rst_ni           in   1          async active-low reset
//  en_valid_i       in   1          east/north child request valid
//  en_ready_o       out  1          east/north request accepted when valid&ready
//  en_level_i       in   LVL_WIDTH  east/north request level
//  en_id_i          in   ID_WIDTH   east/north barrier id
//  ws_valid_i/ws_ready_o/ws_level_i/ws_id_i   same set for west/south child
//  up_valid_o       out  1          request to parent valid (registered)
//  up_ready_i       in   1          parent accepts
//  up_level_o       out  LVL_WIDTH  forwarded level (unchanged)
//  up_id_o          out  ID_WIDTH   forwarded id
//  up_src_o         out  SD_WIDTH   sd_e source mask of forwarded request
//  dn_valid_i       in   1          response from parent valid
//  dn_ready_o       out  1          parent response accepted
//  dn_id_i          in   ID_WIDTH   parent response id
//  dn_dst_i         in   SD_WIDTH   sd_e destination mask
//  rsp_valid_o      out  1          response to children valid (registered)
//  rsp_ready_i      in   1          children accept
//  rsp_id_o         out  ID_WIDTH   completed barrier id
//  rsp_dst_o        out  SD_WIDTH   sd_e destination mask
//  err_o            out  1          1-cycle pulse: protocol error
// BEHAVIOUR
//  Reset: all outputs 0, arrival RF cleared, RR pointer = EN. Reset mid-op drops all state.
//  Classify each valid req: LOCAL (level==NODE_LEVEL), FWD (level>NODE_LEVEL), ILL (<).
//  Slots: up register (1 entry), rsp register (1 entry); slot free = !valid | ready_i.
//  ILL: always ready; consumed, dropped, err_o=1 next cycle.
//  FWD: needs free up slot. Both children FWD with equal level&id same cycle: both accepted,
//   one up entry with src=SD_BOTH. Otherwise one per cycle by RR; src=SD_EAST_NORTH/
//   SD_WEST_SOUTH per winner; loser ready=0.
//  LOCAL: one per cycle by RR, except both LOCAL same id same cycle with RF[id]==00: both
//   accepted, completion. Single arrival from X: partner bit set -> clear RF[id], issue
//   rsp (id, SD_BOTH); partner clear, own clear -> set own bit, no rsp; own already set ->
//   consumed, RF unchanged, err_o pulse. Completion needs free rsp slot, else ready=0.
//  Response merge: dn has priority over local completion for rsp slot; dn_ready_o = rsp
//   slot free. Local completion blocked when dn takes slot (winner ready=0). dn passes
//   id/dst unchanged, latency 1.
//  RR: one EN/WS pointer shared by FWD and LOCAL contention; toggles only after a
//   contended grant. FWD vs LOCAL from different children: independent, both may proceed.
//  Latency: accepted req -> up_valid_o or rsp_valid_o next cycle. Outputs held stable
//   while valid & !ready. Full throughput 1 req/cycle per slot when ready_i held high.
//  RF update and rsp issue are atomic in the accept cycle; no hazard on back-to-back same id.
// TESTING
//  EN LOCAL id1, next cycle WS LOCAL id1 -> rsp id1 dst=2'b11 on cycle after 2nd accept; RF[1]=00.
//  EN and WS LOCAL id2 same cycle, RF empty -> both ready=1, single rsp id2 dst=2'b11.
//  EN LOCAL id0 twice (no WS) -> 2nd accepted, err_o pulses 1 cycle, no rsp, RF[0]=01.
//  Both FWD level=3 id3 same cycle -> one up req level3 id3 src=2'b11; different ids ->
//   EN first, WS next cycle; repeat contention -> WS wins first (RR).
//  up_ready_i=0 for 5 cycles with FWD streaming -> up_* held stable, en_ready_o=0, no loss.
//  dn_valid_i id1 dst=2'b10 same cycle as local completion id2 -> rsp id1 first, id2 next.
//  Assert rst_ni mid-barrier (RF bit set, up/rsp valid) -> outputs 0, RF clear.

Source files
------------

// File: rtl/fractal_sync_arb.sv
// fractal_sync_arb: per-node request arbiter/controller of the fractal sync tree.
// Takes barrier requests from the east/north (en) and west/south (ws) children.
// A request whose level equals NODE_LEVEL is terminated here against a direct-mapped
// arrival register file. A request with a higher level is forwarded to the parent.
// A request with a lower level is dropped and flagged on err_o. Local completions and
// parent responses are merged onto the single child-response channel.
//
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   en_valid_i/en_ready_o/en_level_i/en_id_i   east/north child request
//   ws_valid_i/ws_ready_o/ws_level_i/ws_id_i   west/south child request
//   up_valid_o/up_ready_i/up_level_o/up_id_o/up_src_o   request to parent (registered)
//   dn_valid_i/dn_ready_o/dn_id_i/dn_dst_i  response from parent
//   rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_dst_o   response to children (registered)
//   err_o                                  one-cycle protocol error pulse
module fractal_sync_arb #(
  parameter int unsigned  LVL_WIDTH  = 4,
  parameter int unsigned  ID_WIDTH   = 2,
  parameter int unsigned  NODE_LEVEL = 1,
  localparam int unsigned SD_WIDTH   = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_valid_i,
  output logic                 en_ready_o,
  input  logic [LVL_WIDTH-1:0] en_level_i,
  input  logic [ID_WIDTH-1:0]  en_id_i,
  input  logic                 ws_valid_i,
  output logic                 ws_ready_o,
  input  logic [LVL_WIDTH-1:0] ws_level_i,
  input  logic [ID_WIDTH-1:0]  ws_id_i,
  output logic                 up_valid_o,
  input  logic                 up_ready_i,
  output logic [LVL_WIDTH-1:0] up_level_o,
  output logic [ID_WIDTH-1:0]  up_id_o,
  output logic [SD_WIDTH-1:0]  up_src_o,
  input  logic                 dn_valid_i,
  output logic                 dn_ready_o,
  input  logic [ID_WIDTH-1:0]  dn_id_i,
  input  logic [SD_WIDTH-1:0]  dn_dst_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ID_WIDTH-1:0]  rsp_id_o,
  output logic [SD_WIDTH-1:0]  rsp_dst_o,
  output logic                 err_o
);

  localparam int unsigned          NUM_IDS  = 1 << ID_WIDTH;
  localparam logic [LVL_WIDTH-1:0] NODE_LVL = LVL_WIDTH'(NODE_LEVEL);

  // Source/destination mask: bit0 = east/north, bit1 = west/south.
  typedef enum logic [SD_WIDTH-1:0] {
    SD_NONE       = 2'b00,
    SD_EAST_NORTH = 2'b01,
    SD_WEST_SOUTH = 2'b10,
    SD_BOTH       = 2'b11
  } sd_e;

  // Arrival register file: one EN/WS bit pair per barrier id.
  logic [NUM_IDS-1:0][1:0] rf_q, rf_d;
  // Round-robin pointer: 0 prefers east/north, 1 prefers west/south.
  logic rr_q, rr_d;

  logic                 up_valid_q, up_valid_d;
  logic [LVL_WIDTH-1:0] up_level_q, up_level_d;
  logic [ID_WIDTH-1:0]  up_id_q, up_id_d;
  logic [SD_WIDTH-1:0]  up_src_q, up_src_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
  logic [SD_WIDTH-1:0]  rsp_dst_q, rsp_dst_d;
  logic                 err_q, err_d;

  logic en_loc, en_fwd, en_ill;
  logic ws_loc, ws_fwd, ws_ill;
  logic up_free, rsp_free, loc_slot;

  logic fwd_merge, en_fwd_win, ws_fwd_win, en_fwd_acc, ws_fwd_acc, fwd_rr_hit;

  logic                loc_merge, en_loc_acc, ws_loc_acc, loc_rr_hit;
  logic                cmp_valid, dup_err;
  logic [ID_WIDTH-1:0] cmp_id;
  logic                sel_ws, sel_own, sel_partner, sel_acc;
  logic [ID_WIDTH-1:0] sel_id;

  // Request classification against this node's level.
  always_comb begin
    en_loc = en_valid_i && (en_level_i == NODE_LVL);
    en_fwd = en_valid_i && (en_level_i >  NODE_LVL);
    en_ill = en_valid_i && (en_level_i <  NODE_LVL);
    ws_loc = ws_valid_i && (ws_level_i == NODE_LVL);
    ws_fwd = ws_valid_i && (ws_level_i >  NODE_LVL);
    ws_ill = ws_valid_i && (ws_level_i <  NODE_LVL);
  end

  // Slot availability; a pending parent response always beats a local completion.
  always_comb begin
    up_free  = !up_valid_q  || up_ready_i;
    rsp_free = !rsp_valid_q || rsp_ready_i;
    loc_slot = rsp_free && !dn_valid_i;
  end

  // Forwarding arbitration: identical requests from both children merge into one.
  always_comb begin
    fwd_merge  = en_fwd && ws_fwd && (en_level_i == ws_level_i) && (en_id_i == ws_id_i);
    en_fwd_win = en_fwd && (!ws_fwd || fwd_merge || !rr_q);
    ws_fwd_win = ws_fwd && (!en_fwd || fwd_merge ||  rr_q);
    en_fwd_acc = en_fwd_win && up_free;
    ws_fwd_acc = ws_fwd_win && up_free;
    fwd_rr_hit = en_fwd && ws_fwd && !fwd_merge && up_free;
  end

  // Local termination: arrival RF lookup/update and completion generation.
  always_comb begin
    rf_d        = rf_q;
    loc_merge   = 1'b0;
    en_loc_acc  = 1'b0;
    ws_loc_acc  = 1'b0;
    loc_rr_hit  = 1'b0;
    cmp_valid   = 1'b0;
    cmp_id      = '0;
    dup_err     = 1'b0;
    sel_ws      = 1'b0;
    sel_id      = '0;
    sel_own     = 1'b0;
    sel_partner = 1'b0;
    sel_acc     = 1'b0;

    loc_merge = en_loc && ws_loc && (en_id_i == ws_id_i) && (rf_q[en_id_i] == 2'b00);

    if (loc_merge) begin
      // Both halves arrive together: completion without touching the RF.
      en_loc_acc = loc_slot;
      ws_loc_acc = loc_slot;
      cmp_valid  = loc_slot;
      cmp_id     = en_id_i;
    end else if (en_loc || ws_loc) begin
      sel_ws      = ws_loc && (!en_loc || rr_q);
      sel_id      = sel_ws ? ws_id_i : en_id_i;
      sel_own     = sel_ws ? rf_q[sel_id][1] : rf_q[sel_id][0];
      sel_partner = sel_ws ? rf_q[sel_id][0] : rf_q[sel_id][1];

      if (sel_partner) begin
        // Second half of the barrier: only proceeds when the rsp slot is ours.
        sel_acc = loc_slot;
        if (loc_slot) begin
          rf_d[sel_id] = 2'b00;
          cmp_valid    = 1'b1;
          cmp_id       = sel_id;
        end
      end else if (sel_own) begin
        // Repeated arrival from the same child: swallow it and flag.
        sel_acc = 1'b1;
        dup_err = 1'b1;
      end else begin
        sel_acc = 1'b1;
        if (sel_ws) begin
          rf_d[sel_id][1] = 1'b1;
        end else begin
          rf_d[sel_id][0] = 1'b1;
        end
      end

      en_loc_acc = sel_acc && !sel_ws;
      ws_loc_acc = sel_acc &&  sel_ws;
      loc_rr_hit = sel_acc && en_loc && ws_loc;
    end
  end

  // Handshakes back to the children and the parent.
  always_comb begin
    en_ready_o = en_ill || en_fwd_acc || en_loc_acc;
    ws_ready_o = ws_ill || ws_fwd_acc || ws_loc_acc;
    dn_ready_o = dn_valid_i && rsp_free;
  end

  // Next values of the output slots, pointer and error flag.
  always_comb begin
    up_valid_d  = up_valid_q;
    up_level_d  = up_level_q;
    up_id_d     = up_id_q;
    up_src_d    = up_src_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_dst_d   = rsp_dst_q;
    rr_d        = rr_q ^ (fwd_rr_hit || loc_rr_hit);
    err_d       = en_ill || ws_ill || dup_err;

    if (up_free) begin
      up_valid_d = en_fwd_acc || ws_fwd_acc;
      if (en_fwd_acc) begin
        up_level_d = en_level_i;
        up_id_d    = en_id_i;
        up_src_d   = ws_fwd_acc ? SD_BOTH : SD_EAST_NORTH;
      end else if (ws_fwd_acc) begin
        up_level_d = ws_level_i;
        up_id_d    = ws_id_i;
        up_src_d   = SD_WEST_SOUTH;
      end
    end

    if (rsp_free) begin
      if (dn_valid_i) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = dn_id_i;
        rsp_dst_d   = dn_dst_i;
      end else if (cmp_valid) begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = cmp_id;
        rsp_dst_d   = SD_BOTH;
      end else begin
        rsp_valid_d = 1'b0;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_q        <= '0;
      rr_q        <= 1'b0;
      up_valid_q  <= 1'b0;
      up_level_q  <= '0;
      up_id_q     <= '0;
      up_src_q    <= SD_NONE;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_dst_q   <= SD_NONE;
      err_q       <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      rr_q        <= rr_d;
      up_valid_q  <= up_valid_d;
      up_level_q  <= up_level_d;
      up_id_q     <= up_id_d;
      up_src_q    <= up_src_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_dst_q   <= rsp_dst_d;
      err_q       <= err_d;
    end
  end

  assign up_valid_o  = up_valid_q;
  assign up_level_o  = up_level_q;
  assign up_id_o     = up_id_q;
  assign up_src_o    = up_src_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_dst_o   = rsp_dst_q;
  assign err_o       = err_q;

endmodule
